uart_push_arb: RTL and testbench
================================

Name: uart_push_arb

Overview:
- Shares the single byte-wide UART transmitter between two word-stream requesters (capture-buffer channels), each holding a packet of 16-bit words in a 1-cycle-latency FIFO.
- Round-robin arbitration grants one requester at a time.
- The granted packet's FIFO is popped word by word; each word goes out as two UART bytes, MSB first, with a tx_vld/tx_done handshake per byte.
- Sits between the capture/buffer blocks and the UART TX core.

Parameters:
LEN_W, 20, width of packet length inputs and word counter
SYNC_BYTE, 8'hA5, sync byte sent ahead of each packet when ARB_HDR_EN is defined

Ports:
clk_sys  input  1  system clock
rst_n  input  1  reset
req0  input  1  requester 0 has a complete packet ready (level)
len0  input  LEN_W  requester 0 packet length in words; sampled at grant
rd0  output  1  one-cycle pop strobe to requester 0 FIFO
q0  input  16  requester 0 FIFO data; valid the cycle after rd0
done0  output  1  one-cycle pulse when requester 0 packet completes
req1  input  1  as req0, requester 1
len1  input  LEN_W  as len0
rd1  output  1  as rd0
q1  input  16  as q0
done1  output  1  as done0
tx_data  output  8  byte to UART TX; held stable from tx_vld until tx_done
tx_vld  output  1  one-cycle pulse: tx_data valid, start transmission
tx_done  input  1  one-cycle pulse from UART: byte sent
gnt  output  1  index of granted requester; valid while busy
busy  output  1  high from grant until the done pulse cycle, inclusive

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk_sys.
- On reset: state S_IDLE; rd0, rd1, done0, done1, tx_vld, busy and gnt are 0; tx_data is 8'h00; word counter is 0; last-served pointer is 1, so requester 0 wins first.
- State S_IDLE:
  - If neither req is high, stay.
  - If exactly one req is high, grant it.
  - If both are high, grant the one not last served.
  - On grant: latch len of the granted requester, set gnt, set busy, clear the counter.
  - Next state is S_HDR (with ARB_HDR_EN) or S_RD.
  - If the latched len is 0, go to S_DONE instead: no rd, no bytes sent.
- S_RD: assert rd of the granted requester for exactly 1 cycle, then go to S_LAT.
- S_LAT: capture q of the granted requester into the word register, then go to S_TXH.
- S_TXH: tx_data = word[15:8], pulse tx_vld, then go to S_WTH.
- S_WTH: wait for tx_done, then go to S_TXL.
- S_TXL: tx_data = word[7:0], pulse tx_vld, then go to S_WTL.
- S_WTL: wait for tx_done.
  - If counter == len-1, go to S_DONE.
  - Otherwise increment the counter and go to S_RD.
- S_DONE: pulse the done of the granted requester, update the last-served pointer to gnt, drop busy on the following cycle, return to S_IDLE.
- Minimum period is 6 cycles per word when tx_done returns one cycle after tx_vld.
- tx_done is honoured only in wait states; tx_done in any other state is ignored.
- A req deasserting mid-packet is ignored; the packet runs to its latched len.
- A req change in the S_DONE cycle is evaluated in the next S_IDLE.
- No rd is ever asserted while not busy, and never for the non-granted requester.
- Counter arithmetic is LEN_W bits. len of 2^LEN_W-1 is legal; no wrap occurs before done.
- Reset asserted mid-packet aborts immediately. Partial FIFO contents are the requester's responsibility.

Optional Feature:
- Macro ARB_HDR_EN.
- Defined: after grant, state S_HDR sends SYNC_BYTE, then an ID byte {7'b0, gnt}, each with its own tx_vld/tx_done handshake, then goes to S_RD. For len=0 the header is still sent, then S_DONE.
- Undefined: S_HDR does not exist; grant goes directly to S_RD (or S_DONE).

Test Plan:
- req0=1, len0=2, FIFO0 words 16'h1234, 16'h5678, tx_done 1 cycle after each tx_vld -> tx_data bytes 12, 34, 56, 78; two rd0 pulses; one done0; no rd1.
- req0 and req1 high together from reset, len=1 each -> requester 0 served first, then requester 1; gnt 0 then 1; done0 precedes done1.
- Both held high continuously for 4 packets -> grants alternate 0, 1, 0, 1.
- req1=1, len1=0 -> done1 pulses within 3 cycles of grant; no rd1; no tx_vld (without ARB_HDR_EN).
- tx_done delayed 50 cycles; spurious tx_done in S_RD -> tx_data held stable 50 cycles; spurious pulse ignored; byte count unchanged.
- rst_n low during S_WTH of word 1 of 3 -> all outputs 0 immediately; after release, a new req0 restarts from word 0.
- With ARB_HDR_EN, req1, len1=1, word 16'hBEEF -> bytes A5, 01, BE, EF.

Source files
------------

// File: rtl/uart_push_arb_if.sv
// rtl/uart_push_arb_if.sv - requester, UART TX and status signals of uart_push_arb
interface uart_push_arb_if #(
   parameter int LEN_W = 20
) ();
   logic             req0;
   logic [LEN_W-1:0] len0;
   logic             rd0;
   logic [15:0]      q0;
   logic             done0;
   logic             req1;
   logic [LEN_W-1:0] len1;
   logic             rd1;
   logic [15:0]      q1;
   logic             done1;
   logic [7:0]       tx_data;
   logic             tx_vld;
   logic             tx_done;
   logic             gnt;
   logic             busy;

   modport slave (
      input  req0, len0, q0, req1, len1, q1, tx_done,
      output rd0, done0, rd1, done1, tx_data, tx_vld, gnt, busy
   );

   modport master (
      output req0, len0, q0, req1, len1, q1, tx_done,
      input  rd0, done0, rd1, done1, tx_data, tx_vld, gnt, busy
   );
endinterface

// File: rtl/uart_push_arb.sv
// rtl/uart_push_arb.sv - round-robin arbiter pushing two 16-bit word streams out one UART TX
// Optional ARB_HDR_EN: prefix each packet with SYNC_BYTE and a requester ID byte.
module uart_push_arb #(
   parameter int         LEN_W     = 20,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input logic           clk_sys,
   input logic           rst_n,
   uart_push_arb_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE,
`ifdef ARB_HDR_EN
      S_HDR,
      S_WHS,
      S_HID,
      S_WHI,
`endif
      S_RD,
      S_LAT,
      S_TXH,
      S_WTH,
      S_TXL,
      S_WTL,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic             gnt_q;
   logic             busy_q;
   logic             last_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] cnt_q;
   logic [7:0]       word_lo_q;
   logic [7:0]       tx_data_q;

   logic             any_req;
   logic             pick;
   logic [LEN_W-1:0] pick_len;
   logic [15:0]      q_sel;
   logic             last_word;
   logic             rd0, rd1, done0, done1, tx_vld;

   // With both requesting, the one not served last wins.
   assign any_req   = bus.req0 | bus.req1;
   assign pick      = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
   assign pick_len  = pick ? bus.len1 : bus.len0;
   assign q_sel     = gnt_q ? bus.q1 : bus.q0;
   assign last_word = (cnt_q == len_q - LEN_W'(1));

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      rd0     = 1'b0;
      rd1     = 1'b0;
      done0   = 1'b0;
      done1   = 1'b0;
      tx_vld  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
`ifdef ARB_HDR_EN
               state_d = S_HDR;
`else
               state_d = (pick_len == '0) ? S_DONE : S_RD;
`endif
            end
         end
`ifdef ARB_HDR_EN
         S_HDR: begin
            tx_vld  = 1'b1;
            state_d = S_WHS;
         end
         S_WHS: if (bus.tx_done) state_d = S_HID;
         S_HID: begin
            tx_vld  = 1'b1;
            state_d = S_WHI;
         end
         S_WHI: if (bus.tx_done) state_d = (len_q == '0) ? S_DONE : S_RD;
`endif
         S_RD: begin
            rd0     = ~gnt_q;
            rd1     = gnt_q;
            state_d = S_LAT;
         end
         S_LAT: state_d = S_TXH;
         S_TXH: begin
            tx_vld  = 1'b1;
            state_d = S_WTH;
         end
         S_WTH: if (bus.tx_done) state_d = S_TXL;
         S_TXL: begin
            tx_vld  = 1'b1;
            state_d = S_WTL;
         end
         S_WTL: if (bus.tx_done) state_d = last_word ? S_DONE : S_RD;
         S_DONE: begin
            done0   = ~gnt_q;
            done1   = gnt_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // tx_data is a register so it stays put for the whole byte handshake.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q     <= 1'b0;
         busy_q    <= 1'b0;
         last_q    <= 1'b1;
         len_q     <= '0;
         cnt_q     <= '0;
         word_lo_q <= 8'h00;
         tx_data_q <= 8'h00;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (any_req) begin
                  gnt_q  <= pick;
                  busy_q <= 1'b1;
                  len_q  <= pick_len;
                  cnt_q  <= '0;
`ifdef ARB_HDR_EN
                  tx_data_q <= SYNC_BYTE;
`endif
               end
            end
`ifdef ARB_HDR_EN
            S_WHS: if (bus.tx_done) tx_data_q <= {7'b0, gnt_q};
`endif
            S_LAT: begin
               word_lo_q <= q_sel[7:0];
               tx_data_q <= q_sel[15:8];
            end
            S_WTH: if (bus.tx_done) tx_data_q <= word_lo_q;
            S_WTL: if (bus.tx_done && !last_word) cnt_q <= cnt_q + LEN_W'(1);
            S_DONE: begin
               last_q <= gnt_q;
               busy_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.rd0     = rd0;
   assign bus.rd1     = rd1;
   assign bus.done0   = done0;
   assign bus.done1   = done1;
   assign bus.tx_vld  = tx_vld;
   assign bus.tx_data = tx_data_q;
   assign bus.gnt     = gnt_q;
   assign bus.busy    = busy_q;

endmodule

// File: tb/tb_uart_push_arb.sv
// tb/tb_uart_push_arb.sv - scoreboard bench for uart_push_arb with packet-level reference model
module tb_uart_push_arb;
   localparam int LEN_W = 20;
`ifdef ARB_HDR_EN
   localparam int HDR_BYTES = 2;
`else
   localparam int HDR_BYTES = 0;
`endif

   logic clk_sys = 1'b0;
   logic rst_n;
   logic done_drv = 1'b0;
   logic spur_drv = 1'b0;

   always #5 clk_sys = ~clk_sys;

   uart_push_arb_if #(.LEN_W(LEN_W)) bus ();

   uart_push_arb #(.LEN_W(LEN_W), .SYNC_BYTE(8'hA5)) dut (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   assign bus.tx_done = done_drv | spur_drv;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int nvld = 0;
   int n_spur = 0;
   int uart_delay = 0;
   bit spur_en = 1'b0;
   int model_last = 1;

   logic [7:0]  exp_bytes[$];
   int          exp_done[$];
   int          exp_len[$];
   int          vld_cyc[$];
   logic [15:0] fifo0[$], fifo1[$];
   int          plen0[$], plen1[$];
   logic [15:0] pw0[$], pw1[$];

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, req);
   endtask

   task automatic add_pkt(input int r, input int len, input bit fixed,
                          input logic [15:0] wa, input logic [15:0] wb);
      logic [15:0] w;
      for (int k = 0; k < len; k++) begin
         w = 16'($urandom);
         if (fixed && k == 0) w = wa;
         if (fixed && k == 1) w = wb;
         if (r == 0) pw0.push_back(w);
         else        pw1.push_back(w);
      end
      if (r == 0) plen0.push_back(len);
      else        plen1.push_back(len);
   endtask

   task automatic load_next(input int r);
      int len;
      if (r == 0) begin
         if (plen0.size() > 0) begin
            len = plen0.pop_front();
            bus.len0 = LEN_W'(len);
            for (int k = 0; k < len; k++) fifo0.push_back(pw0.pop_front());
            bus.req0 = 1'b1;
         end else bus.req0 = 1'b0;
      end else begin
         if (plen1.size() > 0) begin
            len = plen1.pop_front();
            bus.len1 = LEN_W'(len);
            for (int k = 0; k < len; k++) fifo1.push_back(pw1.pop_front());
            bus.req1 = 1'b1;
         end else bus.req1 = 1'b0;
      end
   endtask

   // Service order and byte stream of all pending packets, both requesters raised together.
   task automatic start_round();
      int i0 = 0, i1 = 0, o0 = 0, o1 = 0, pick, len;
      logic [15:0] w;
      while (i0 < plen0.size() || i1 < plen1.size()) begin
         if (i0 < plen0.size() && i1 < plen1.size()) pick = 1 - model_last;
         else pick = (i0 < plen0.size()) ? 0 : 1;
         if (HDR_BYTES != 0) begin
            exp_bytes.push_back(8'hA5);
            exp_bytes.push_back(8'(pick));
         end
         len = (pick == 1) ? plen1[i1] : plen0[i0];
         for (int k = 0; k < len; k++) begin
            w = (pick == 1) ? pw1[o1 + k] : pw0[o0 + k];
            exp_bytes.push_back(w[15:8]);
            exp_bytes.push_back(w[7:0]);
         end
         if (pick == 1) begin o1 += len; i1++; end
         else begin o0 += len; i0++; end
         exp_done.push_back(pick);
         exp_len.push_back(len);
         model_last = pick;
      end
      load_next(0);
      load_next(1);
   endtask

   task automatic wait_round(input int budget);
      int t = 0;
      @(negedge clk_sys);
      while ((exp_done.size() != 0 || bus.busy) && t < budget) begin
         @(negedge clk_sys);
         t++;
      end
      chk("round_in_time", t < budget, 1);
      chk("round_done_left", exp_done.size(), 0);
      chk("round_bytes_left", exp_bytes.size(), 0);
      chk("idle_busy", bus.busy, 0);
      repeat (3) @(negedge clk_sys);
   endtask

   // rd/done monitor and FIFO models.
   initial begin
      int rdc = 0, gcyc = 0, id;
      logic busy_p = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (!rst_n) begin
            rdc = 0;
            busy_p = 1'b0;
            continue;
         end
         if (bus.busy && !busy_p) gcyc = cyc;
         busy_p = bus.busy;
         if (bus.rd0 || bus.rd1) begin
            id = bus.rd1 ? 1 : 0;
            chk("rd_busy", bus.busy, 1);
            chk("rd_both", bus.rd0 & bus.rd1, 0);
            chk("rd_expected", exp_done.size() > 0, 1);
            if (exp_done.size() > 0) chk("rd_req", id, exp_done[0]);
            rdc++;
            if (id == 0) begin
               chk("fifo0_nonempty", fifo0.size() > 0, 1);
               if (fifo0.size() > 0) bus.q0 = fifo0.pop_front();
            end else begin
               chk("fifo1_nonempty", fifo1.size() > 0, 1);
               if (fifo1.size() > 0) bus.q1 = fifo1.pop_front();
            end
         end
         if (bus.done0 || bus.done1) begin
            id = bus.done1 ? 1 : 0;
            chk("done_both", bus.done0 & bus.done1, 0);
            chk("done_busy", bus.busy, 1);
            chk("done_expected", exp_done.size() > 0, 1);
            if (exp_done.size() > 0) begin
               chk("done_req", id, exp_done[0]);
               chk("done_gnt", bus.gnt, exp_done[0]);
               chk("rd_count", rdc, exp_len[0]);
               if (HDR_BYTES == 0 && exp_len[0] == 0) chk("len0_latency", (cyc - gcyc) <= 3, 1);
               void'(exp_done.pop_front());
               void'(exp_len.pop_front());
            end
            rdc = 0;
            load_next(id);
         end
      end
   end

   // UART TX model: byte scoreboard, hold check, tx_done after uart_delay cycles.
   initial begin
      logic [7:0] got;
      int d;
      bit bad, ab;
      forever begin
         @(negedge clk_sys);
         if (rst_n && bus.tx_vld) begin
            got = bus.tx_data;
            nvld++;
            vld_cyc.push_back(cyc);
            chk("byte_expected", exp_bytes.size() > 0, 1);
            if (exp_bytes.size() > 0) chk("tx_byte", got, exp_bytes.pop_front());
            d = (uart_delay > 0) ? uart_delay : int'($urandom_range(1, 3));
            bad = 1'b0;
            ab = 1'b0;
            for (int i = 0; i < d; i++) begin
               @(posedge clk_sys);
               #1;
               if (!rst_n) begin
                  ab = 1'b1;
                  break;
               end
               if (bus.tx_data !== got) bad = 1'b1;
            end
            if (!ab) begin
               chk("tx_hold", bad, 0);
               done_drv = 1'b1;
               @(posedge clk_sys);
               #1;
               done_drv = 1'b0;
            end
         end
      end
   end

   // Spurious tx_done during the FIFO read cycle.
   initial begin
      forever begin
         @(negedge clk_sys);
         if (spur_en && (bus.rd0 || bus.rd1)) begin
            spur_drv = 1'b1;
            n_spur++;
            @(negedge clk_sys);
            spur_drv = 1'b0;
         end
      end
   end

   initial begin
      int t, target;
      rst_n = 1'b0;
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.len0 = '0;   bus.len1 = '0;
      bus.q0 = 16'h0;  bus.q1 = 16'h0;
      repeat (3) @(negedge clk_sys);
      chk("rst_busy", bus.busy, 0);
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_tx_vld", bus.tx_vld, 0);
      chk("rst_tx_data", bus.tx_data, 0);
      chk("rst_rd", {bus.rd0, bus.rd1}, 0);
      chk("rst_done", {bus.done0, bus.done1}, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk_sys);

      // both requesting from reset: requester 0 first
      add_pkt(0, 1, 1'b0, 16'h0, 16'h0);
      add_pkt(1, 1, 1'b0, 16'h0, 16'h0);
      start_round();
      wait_round(1000);

      // two-word packet, minimum-latency UART
      uart_delay = 1;
      vld_cyc.delete();
      add_pkt(0, 2, 1'b1, 16'h1234, 16'h5678);
      start_round();
      wait_round(1000);
      chk("vld_count", vld_cyc.size(), HDR_BYTES + 4);
      if (vld_cyc.size() >= HDR_BYTES + 3)
         chk("word_period", vld_cyc[HDR_BYTES + 2] - vld_cyc[HDR_BYTES], 6);

      // zero-length packet
      uart_delay = 0;
      add_pkt(1, 0, 1'b0, 16'h0, 16'h0);
      start_round();
      wait_round(1000);

      // four packets with both held high: alternation
      for (int k = 0; k < 2; k++) begin
         add_pkt(0, 1, 1'b0, 16'h0, 16'h0);
         add_pkt(1, 1, 1'b0, 16'h0, 16'h0);
      end
      start_round();
      wait_round(2000);

      // slow UART and spurious tx_done in the read cycle
      uart_delay = 50;
      spur_en = 1'b1;
      n_spur = 0;
      add_pkt(1, 2, 1'b1, 16'hBEEF, 16'hCAFE);
      start_round();
      wait_round(2000);
      chk("spur_issued", n_spur > 0, 1);
      spur_en = 1'b0;

      // randomized rounds
      uart_delay = 0;
      for (int r = 0; r < 10; r++) begin
         for (int k = $urandom_range(0, 2); k > 0; k--) add_pkt(0, $urandom_range(0, 3), 1'b0, 16'h0, 16'h0);
         for (int k = $urandom_range(0, 2); k > 0; k--) add_pkt(1, $urandom_range(0, 3), 1'b0, 16'h0, 16'h0);
         start_round();
         wait_round(2000);
      end

      // reset while waiting on the high byte of word 1 of 3
      uart_delay = 50;
      target = nvld + HDR_BYTES + 3;
      add_pkt(0, 3, 1'b0, 16'h0, 16'h0);
      start_round();
      t = 0;
      while (nvld < target && t < 1000) begin
         @(negedge clk_sys);
         t++;
      end
      chk("reset_point_reached", nvld >= target, 1);
      repeat (5) @(posedge clk_sys);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_tx_data", bus.tx_data, 0);
      chk("abort_tx_vld", bus.tx_vld, 0);
      chk("abort_rd", {bus.rd0, bus.rd1}, 0);
      chk("abort_gnt", bus.gnt, 0);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      exp_bytes.delete(); exp_done.delete(); exp_len.delete();
      fifo0.delete(); fifo1.delete();
      plen0.delete(); plen1.delete(); pw0.delete(); pw1.delete();
      model_last = 1;
      repeat (3) @(negedge clk_sys);
      rst_n = 1'b1;
      repeat (2) @(negedge clk_sys);
      uart_delay = 1;
      add_pkt(0, 2, 1'b1, 16'hA1B2, 16'hC3D4);
      start_round();
      wait_round(1000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
